// File: rtl/matrix_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_link_pkg
//  Description : Shared state codes and sizing/indexing helpers for the
//                matrix link sequencer and its result serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_link_pkg;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD_A  = 3'd1;
    localparam logic [2:0] c_ST_LOAD_B  = 3'd2;
    localparam logic [2:0] c_ST_COMPUTE = 3'd3;
    localparam logic [2:0] c_ST_SEND    = 3'd4;

    localparam logic [1:0] c_TX_ISSUE   = 2'd0;
    localparam logic [1:0] c_TX_ACK     = 2'd1;
    localparam logic [1:0] c_TX_WAIT    = 2'd2;

    function automatic int bpe_in(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int bpe_out(input int res_w);
        return res_w / 8;
    endfunction

    // Buffers keep a fixed row stride of n_max regardless of the active size.
    function automatic int elem_idx(input int r, input int c, input int n_max);
        return r * n_max + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : result_tx_serializer
//  Description : Issues one byte to the UART transmitter per start/busy
//                handshake and flags completion once busy falls again.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_tx_serializer
    import matrix_link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_go,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_byte_done
);

    logic [1:0] r_tx_st;
    logic [1:0] w_tx_st_nxt;
    logic       w_issue;
    logic       w_byte_done;
    logic [7:0] r_tx_data;
    logic       r_tx_start;

    assign w_issue = i_go && (r_tx_st == c_TX_ISSUE) && !i_tx_busy;

    always_comb begin
        w_tx_st_nxt = r_tx_st;
        w_byte_done = 1'b0;
        if (!i_go) begin
            w_tx_st_nxt = c_TX_ISSUE;
        end else begin
            case (r_tx_st)
                c_TX_ISSUE: if (!i_tx_busy) w_tx_st_nxt = c_TX_ACK;
                c_TX_ACK:   if (i_tx_busy)  w_tx_st_nxt = c_TX_WAIT;
                c_TX_WAIT: begin
                    if (!i_tx_busy) begin
                        w_tx_st_nxt = c_TX_ISSUE;
                        w_byte_done = 1'b1;
                    end
                end
                default:    w_tx_st_nxt = c_TX_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_st    <= c_TX_ISSUE;
            r_tx_data  <= 8'd0;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_st    <= w_tx_st_nxt;
            r_tx_start <= w_issue;
            if (w_issue) begin
                r_tx_data <= i_byte;
            end
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_start  = r_tx_start;
    assign o_byte_done = w_byte_done;

endmodule
`default_nettype wire

// File: rtl/matrix_link_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_link_sequencer
//  Description : Loads size, A and B from a UART byte stream, starts the
//                multiplier and streams the active result region back out.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_link_sequencer
    import matrix_link_pkg::*;
#(
    parameter int N_MAX  = 10,
    parameter int DATA_W = 8,
    parameter int RES_W  = 16,
    parameter int SZ_W   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic [7:0]                      tx_data,
    output logic                            tx_start,
    input  logic                            tx_busy,
    output logic                            mult_start,
    input  logic                            mult_done,
    input  logic [N_MAX*N_MAX*RES_W-1:0]    mult_result,
    output logic [N_MAX*N_MAX*DATA_W-1:0]   a_flat,
    output logic [N_MAX*N_MAX*DATA_W-1:0]   b_flat,
    output logic [SZ_W-1:0]                 matrix_size,
    output logic [2:0]                      state,
    output logic                            size_err,
    output logic                            rx_drop,
    output logic                            frame_done
);

    localparam int c_BPE_IN  = bpe_in(DATA_W);
    localparam int c_BPE_OUT = bpe_out(RES_W);
    localparam int c_FLAT_W  = N_MAX * N_MAX * DATA_W;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [SZ_W-1:0]     r_size;
    logic [SZ_W-1:0]     r_row;
    logic [SZ_W-1:0]     r_col;
    logic [7:0]          r_byte;
    logic [c_FLAT_W-1:0] r_a_flat;
    logic [c_FLAT_W-1:0] r_b_flat;
    logic                r_mult_start;
    logic                r_size_err;
    logic                r_rx_drop;
    logic                r_frame_done;

    logic [SZ_W-1:0]     w_size_m1;
    logic                w_size_ok;
    logic                w_loading;
    logic                w_sending;
    logic                w_byte_last;
    logic                w_elem_last;
    logic                w_adv;
    logic                w_load_done;
    logic                w_send_done;
    logic                w_byte_done;
    logic [7:0]          w_send_byte;
    int                  w_idx;

    assign w_size_m1   = r_size - SZ_W'(1);
    assign w_size_ok   = (rx_data != 8'd0) && ({24'd0, rx_data} <= 32'(N_MAX));
    assign w_loading   = (r_state == c_ST_LOAD_A) || (r_state == c_ST_LOAD_B);
    assign w_sending   = (r_state == c_ST_SEND);
    assign w_byte_last = w_sending ? (r_byte == 8'(c_BPE_OUT - 1))
                                   : (r_byte == 8'(c_BPE_IN - 1));
    assign w_elem_last = (r_row == w_size_m1) && (r_col == w_size_m1);
    assign w_adv       = (w_loading && rx_valid) || (w_sending && w_byte_done);
    assign w_load_done = w_loading && rx_valid && w_byte_last && w_elem_last;
    assign w_send_done = w_sending && w_byte_done && w_byte_last && w_elem_last;
    assign w_idx       = elem_idx(int'(r_row), int'(r_col), N_MAX);
    assign w_send_byte = mult_result[w_idx*RES_W + int'(r_byte)*8 +: 8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (rx_valid && w_size_ok)        w_state_nxt = c_ST_LOAD_A;
            c_ST_LOAD_A:  if (w_load_done)                  w_state_nxt = c_ST_LOAD_B;
            c_ST_LOAD_B:  if (w_load_done)                  w_state_nxt = c_ST_COMPUTE;
            // A done coinciding with the start pulse belongs to a previous job.
            c_ST_COMPUTE: if (mult_done && !r_mult_start)   w_state_nxt = c_ST_SEND;
            c_ST_SEND:    if (w_send_done)                  w_state_nxt = c_ST_IDLE;
            default:                                        w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_size       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_byte       <= 8'd0;
            r_a_flat     <= '0;
            r_b_flat     <= '0;
            r_mult_start <= 1'b0;
            r_size_err   <= 1'b0;
            r_rx_drop    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mult_start <= (r_state == c_ST_LOAD_B) && w_load_done;
            r_size_err   <= (r_state == c_ST_IDLE) && rx_valid && !w_size_ok;
            r_rx_drop    <= rx_valid && ((r_state == c_ST_COMPUTE) || w_sending);
            r_frame_done <= w_send_done;

            if ((r_state == c_ST_IDLE) && rx_valid && w_size_ok) begin
                r_size   <= rx_data[SZ_W-1:0];
                r_a_flat <= '0;
                r_b_flat <= '0;
                r_row    <= '0;
                r_col    <= '0;
                r_byte   <= 8'd0;
            end

            if ((r_state == c_ST_LOAD_A) && rx_valid) begin
                r_a_flat[w_idx*DATA_W + int'(r_byte)*8 +: 8] <= rx_data;
            end
            if ((r_state == c_ST_LOAD_B) && rx_valid) begin
                r_b_flat[w_idx*DATA_W + int'(r_byte)*8 +: 8] <= rx_data;
            end

            // Byte lane, then column, then row; wraps to zero after the last element.
            if (w_adv) begin
                if (w_byte_last) begin
                    r_byte <= 8'd0;
                    if (r_col == w_size_m1) begin
                        r_col <= '0;
                        r_row <= (r_row == w_size_m1) ? '0 : r_row + SZ_W'(1);
                    end else begin
                        r_col <= r_col + SZ_W'(1);
                    end
                end else begin
                    r_byte <= r_byte + 8'd1;
                end
            end
        end
    end

    result_tx_serializer u_tx (
        .clk         (clk),
        .rst         (rst),
        .i_byte      (w_send_byte),
        .i_go        (w_sending),
        .i_tx_busy   (tx_busy),
        .o_tx_data   (tx_data),
        .o_tx_start  (tx_start),
        .o_byte_done (w_byte_done)
    );

    assign a_flat      = r_a_flat;
    assign b_flat      = r_b_flat;
    assign matrix_size = r_size;
    assign state       = r_state;
    assign mult_start  = r_mult_start;
    assign size_err    = r_size_err;
    assign rx_drop     = r_rx_drop;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_link_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_link_sequencer
//  Description : Directed and randomized frames for matrix_link_sequencer,
//                checked against a matrix-product reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_link_sequencer;

    localparam int N_MAX  = 10;
    localparam int DATA_W = 8;
    localparam int RES_W  = 16;
    localparam int SZ_W   = 4;
    localparam int NE     = N_MAX * N_MAX;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [7:0]             rx_data = 8'd0;
    logic                   rx_valid = 1'b0;
    logic [7:0]             tx_data;
    logic                   tx_start;
    logic                   tx_busy = 1'b0;
    logic                   mult_start;
    logic                   mult_done = 1'b0;
    logic [NE*RES_W-1:0]    mult_result = '0;
    logic [NE*DATA_W-1:0]   a_flat;
    logic [NE*DATA_W-1:0]   b_flat;
    logic [SZ_W-1:0]        matrix_size;
    logic [2:0]             state;
    logic                   size_err;
    logic                   rx_drop;
    logic                   frame_done;

    always #5 clk = ~clk;

    matrix_link_sequencer #(
        .N_MAX (N_MAX),
        .DATA_W(DATA_W),
        .RES_W (RES_W),
        .SZ_W  (SZ_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .mult_start (mult_start),
        .mult_done  (mult_done),
        .mult_result(mult_result),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .matrix_size(matrix_size),
        .state      (state),
        .size_err   (size_err),
        .rx_drop    (rx_drop),
        .frame_done (frame_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int ms_cnt = 0, fd_cnt = 0, se_cnt = 0, rd_cnt = 0, ts_cnt = 0;
    int start_viol = 0;
    int busy_hold = 0, busy_left = 0;
    bit prev_start = 1'b0;
    logic [7:0] txq[$];
    int ma[N_MAX][N_MAX];
    int mb[N_MAX][N_MAX];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Transmitter model: busy rises in the start cycle and holds busy_hold more cycles.
    always @(negedge clk) begin
        if (mult_start) ms_cnt++;
        if (frame_done) fd_cnt++;
        if (size_err)   se_cnt++;
        if (rx_drop)    rd_cnt++;
        if (tx_start) begin
            ts_cnt++;
            txq.push_back(tx_data);
            if (prev_start || tx_busy) start_viol++;
        end
        prev_start = tx_start;
        if (tx_start) begin
            tx_busy   = 1'b1;
            busy_left = busy_hold;
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            tx_busy = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic logic [15:0] prod(input int n, input int r, input int c);
        int s = 0;
        for (int k = 0; k < n; k++) s += ma[r][k] * mb[k][c];
        return 16'(s);
    endfunction

    task automatic fill_random(input int n);
        for (int r = 0; r < N_MAX; r++)
            for (int c = 0; c < N_MAX; c++) begin
                ma[r][c] = (r < n && c < n) ? int'($urandom_range(0, 255)) : 0;
                mb[r][c] = (r < n && c < n) ? int'($urandom_range(0, 255)) : 0;
            end
    endtask

    task automatic fill_t1();
        fill_random(0);
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    endtask

    task automatic check_t1_bytes(input string tag);
        logic [7:0] t1[8];
        t1 = '{8'd19, 8'd0, 8'd22, 8'd0, 8'd43, 8'd0, 8'd50, 8'd0};
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_byte%0d", tag, i), (i < txq.size()) ? txq[i] : 8'hxx, t1[i]);
    endtask

    task automatic run_frame(input int n, input bit size_sent, input int hold, input bit inject);
        int ms0, fd0, rd0, guard;
        logic [7:0] exp_bytes[$];
        busy_hold = hold;
        for (int i = 0; i < NE; i++) mult_result[i*RES_W +: RES_W] = 16'($urandom);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                mult_result[(r*N_MAX+c)*RES_W +: RES_W] = prod(n, r, c);
                exp_bytes.push_back(prod(n, r, c) & 16'h00FF);
                exp_bytes.push_back(prod(n, r, c) >> 8);
            end
        txq.delete();
        ms0 = ms_cnt; fd0 = fd_cnt; rd0 = rd_cnt;
        if (!size_sent) begin
            send_byte(8'(n));
            check("state_after_size", state, 1);
            check("matrix_size", matrix_size, n);
        end
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(8'(ma[r][c]));
            end
        check("state_load_b", state, 2);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send_byte(8'(mb[r][c]));
            end
        check("state_compute", state, 3);
        check("mult_start_first_cycle", mult_start, 1);
        mult_done = 1'b1;
        @(negedge clk);
        mult_done = 1'b0;
        check("done_in_start_cycle_ignored", state, 3);
        check("mult_start_one_cycle", mult_start, 0);
        if (inject) begin
            send_byte(8'hAA);
            check("drop_in_compute_pulse", rx_drop, 1);
            check("drop_in_compute_state", state, 3);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("waiting_for_done", state, 3);
        mult_done = 1'b1;
        @(negedge clk);
        mult_done = 1'b0;
        check("state_send", state, 4);
        if (inject) begin
            send_byte(8'hAA);
            check("drop_in_send_pulse", rx_drop, 1);
            check("drop_in_send_state", state, 4);
        end
        guard = 0;
        while (fd_cnt == fd0 && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("frame_done_once", fd_cnt - fd0, 1);
        check("state_idle_after_frame", state, 0);
        check("mult_start_count", ms_cnt - ms0, 1);
        check("rx_drop_count", rd_cnt - rd0, inject ? 2 : 0);
        check("tx_byte_count", txq.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            check($sformatf("tx_byte[%0d]", i), (i < txq.size()) ? txq[i] : 8'hxx, exp_bytes[i]);
        for (int r = 0; r < N_MAX; r++)
            for (int c = 0; c < N_MAX; c++) begin
                check($sformatf("a_flat[%0d]", r*N_MAX+c), a_flat[(r*N_MAX+c)*DATA_W +: DATA_W],
                      (r < n && c < n) ? ma[r][c] : 0);
                check($sformatf("b_flat[%0d]", r*N_MAX+c), b_flat[(r*N_MAX+c)*DATA_W +: DATA_W],
                      (r < n && c < n) ? mb[r][c] : 0);
            end
    endtask

    initial begin
        int ts0;
        int rn;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_a_flat_clear", a_flat === '0, 1);
        check("rst_b_flat_clear", b_flat === '0, 1);
        check("rst_matrix_size", matrix_size, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_pulses", {tx_start, mult_start, size_err, rx_drop, frame_done}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 2x2 frame with the known product
        fill_t1();
        run_frame(2, 1'b0, 0, 1'b0);
        check_t1_bytes("t1");

        // Out-of-range size bytes, then a valid size continues into a frame
        send_byte(8'd0);
        check("size_err_0", size_err, 1);
        check("size_err_0_state", state, 0);
        send_byte(8'd11);
        check("size_err_11", size_err, 1);
        check("size_err_11_state", state, 0);
        send_byte(8'd255);
        check("size_err_255", size_err, 1);
        check("size_err_255_state", state, 0);
        send_byte(8'd1);
        check("size1_state", state, 1);
        check("size1_matrix_size", matrix_size, 1);
        fill_random(1);
        run_frame(1, 1'b1, 1, 1'b0);

        // Bytes arriving during COMPUTE and SEND are dropped
        fill_t1();
        run_frame(2, 1'b0, 2, 1'b1);
        check_t1_bytes("t3");

        // Reset in the middle of loading B
        fill_random(2);
        send_byte(8'd2);
        for (int i = 0; i < 4; i++) send_byte(8'(ma[i/2][i%2]));
        for (int i = 0; i < 3; i++) send_byte(8'(mb[i/2][i%2]));
        ts0 = ts_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state", state, 0);
        check("midrst_a_clear", a_flat === '0, 1);
        check("midrst_b_clear", b_flat === '0, 1);
        check("midrst_size", matrix_size, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_no_tx_start", ts_cnt - ts0, 0);
        check("midrst_still_idle", state, 0);
        fill_random(1);
        run_frame(1, 1'b0, 0, 1'b0);

        // Long transmitter busy
        fill_t1();
        run_frame(2, 1'b0, 40, 1'b0);
        check_t1_bytes("t5");

        // Full-size identity
        for (int r = 0; r < N_MAX; r++)
            for (int c = 0; c < N_MAX; c++) begin
                ma[r][c] = (r == c) ? 1 : 0;
                mb[r][c] = (r == c) ? 1 : 0;
            end
        run_frame(N_MAX, 1'b0, 0, 1'b0);

        // Randomized frames
        for (int k = 0; k < 4; k++) begin
            rn = int'($urandom_range(1, N_MAX));
            fill_random(rn);
            run_frame(rn, 1'b0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        check("start_protocol_violations", start_viol, 0);
        check("size_err_total", se_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_link_sequencer.md
Name: matrix_link_sequencer

Overview:
Parametrised successor to the UART matrix front-end sequencer. It receives a size byte and then matrices A and B as byte streams from the UART receiver, and packs them into flat operand buffers for the multiplier. It triggers the multiplier with a start/done handshake, then serialises only the active n×n result region back to the UART transmitter, one byte at a time, with a proper start/busy handshake. Unlike the previous generation, it adds runtime size checking, multi-byte elements, and overrun reporting.

Parameters:
N_MAX, 10, largest supported matrix dimension.
DATA_W, 8, operand element width in bits; must be a multiple of 8.
RES_W, 16, result element width in bits; must be a multiple of 8.
SZ_W, 4, width of matrix_size; must satisfy 2^SZ_W > N_MAX.

Ports:
clk  in  1  system (baud-domain) clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle request to the transmitter
tx_busy  in  1  transmitter busy
mult_start  out  1  one-cycle multiplier start
mult_done  in  1  multiplier finished (pulse or level)
mult_result  in  N_MAX*N_MAX*RES_W  flat result; element (r,c) at index r*N_MAX+c
a_flat  out  N_MAX*N_MAX*DATA_W  operand A; same indexing as mult_result
b_flat  out  N_MAX*N_MAX*DATA_W  operand B
matrix_size  out  SZ_W  accepted dimension n
state  out  3  current state code
size_err  out  1  one-cycle pulse when a size byte is rejected
rx_drop  out  1  one-cycle pulse when a byte is ignored
frame_done  out  1  one-cycle pulse after the last result byte completes

Behaviour:
- Reset: state=IDLE; a_flat, b_flat, matrix_size, tx_data = 0; all pulse outputs = 0; all counters = 0. Reset mid-operation aborts the transaction and clears both buffers in the same edge.
- Bytes per element: BPE_IN = DATA_W/8, BPE_OUT = RES_W/8. Multi-byte elements are little-endian.
- Element order is row-major over the active n×n region. Row stride in the buffers is N_MAX, not n.
- States: IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, SEND=4. Codes 5–7 are illegal and recover to IDLE.
- IDLE: on rx_valid, if 1 ≤ rx_data ≤ N_MAX, latch matrix_size=rx_data, zero a_flat and b_flat, reset counters, and go to LOAD_A. Otherwise pulse size_err the next cycle and stay in IDLE.
- LOAD_A / LOAD_B: each rx_valid writes rx_data into byte lane byte_cnt of element (row,col). Counters advance byte→col→row.
- The byte completing element (n-1,n-1) changes state on the same edge it is written. The next rx_valid belongs to the next phase.
- LOAD_B completion enters COMPUTE.
- COMPUTE: mult_start is high exactly in the first COMPUTE cycle. mult_done is sampled only from the following cycle onward, so a done in the start cycle is ignored. A sampled done moves to SEND.
- SEND handshake:
  - TX_ISSUE: when tx_busy=0, drive tx_data with the current result byte and pulse tx_start for one cycle.
  - TX_ACK: wait for tx_busy=1.
  - TX_WAIT: wait for tx_busy=0, then advance byte/col/row.
  - The transmitter must raise busy within one cycle of start.
  - Exactly n*n*BPE_OUT tx_start pulses are produced. No byte is repeated or skipped, however long busy is held.
- After the final TX_WAIT exit: pulse frame_done and return to IDLE. Buffers are held until the next accepted size byte.
- rx_valid in COMPUTE or SEND: byte discarded, rx_drop pulses, no state change.
- tx_data holds its last value between starts.

Decomposition:
- Shared package matrix_link_pkg: state codes, TX sub-state codes, BPE_IN/BPE_OUT functions, and an index function (r,c)→r*N_MAX+c.
- One natural sub-module: result_tx_serializer. It owns TX_ISSUE/TX_ACK/TX_WAIT. Inputs: byte, go, tx_busy. Outputs: tx_data, tx_start, byte_done.
- The parent owns the receive FSM, operand buffers, and result indexing.

Test Plan:
1. Defaults. Send 2, then A=1,2,3,4 and B=5,6,7,8; a product model drives mult_result. Required: a_flat idx0/1/10/11 = 1/2/3/4; one mult_start pulse; tx bytes 19,0,22,0,43,0,50,0; one frame_done.
2. Size bytes 0, then 11, then 255 → three size_err pulses, state stays 0. Then send 1 → state 1, matrix_size=1.
3. rx_valid with byte 0xAA during COMPUTE and again during SEND → two rx_drop pulses; buffers and tx byte sequence unchanged.
4. rst high one cycle after the third byte of B (n=2) → next cycle state=0, a_flat=b_flat=0, no tx_start. A fresh size=1 transaction then completes.
5. tx_busy held high 40 cycles after each start → every tx_start is exactly 1 cycle wide, starts are never back-to-back, and all 8 bytes of test 1 are correct.
6. n=10, A=B=identity, mult_result=identity → 100+100 bytes accepted, 200 tx bytes in pattern 1,0 on the diagonal and 0,0 elsewhere, last byte from index 99.
